enet_gmii_tx_ctrl: RTL
======================

ENET_GMII_TX_CTRL -- requirements
Module: enet_gmii_tx_ctrl

Interface
REQ-001 Parameter IFG_BYTES, default 12, minimum idle cycles (gmii_tx_en low) between frames; legal range 1..255.
REQ-002 Parameter MIN_FRAME, default 60, minimum bytes before FCS (payload plus pad); legal range 1..2047.
REQ-003 gmii_tx_clk  in  1  sole clock: 125 MHz GMII transmit clock, also forwarded to the RGMII TX converter.
REQ-004 gmii_tx_rst  in  1  reset; synchronous to gmii_tx_clk and active-high.
REQ-005 s_data  in  8  frame byte from the transmit buffer, destination MAC first.
REQ-006 s_valid  in  1  s_data is valid.
REQ-007 s_last  in  1  s_data is the final payload byte of the frame.
REQ-008 s_ready  out  1  byte accepted when s_valid&&s_ready.
REQ-009 gmii_tx_en / gmii_tx_er / gmii_txd  out  1/1/8  GMII transmit bus to the RGMII TX converter.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 frame_done  out  1  one-cycle pulse on the last FCS byte, or on the abort cycle.
REQ-012 underrun  out  1  one-cycle pulse when a frame is aborted for an s_valid gap.

Function
REQ-013 FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
REQ-014 IDLE: on s_valid=1, go to PRE; the byte is not consumed.
REQ-015 PRE: 7 cycles, then SFD.
REQ-016 SFD: 1 cycle, then DATA.
REQ-017 DATA: s_ready=1; s_ready SHALL be 0 in every other state.
REQ-018 PAD: emits zero bytes until the byte count equals MIN_FRAME, then FCS.
REQ-019 FCS: 4 cycles, then IFG.
REQ-020 IFG: IFG_BYTES cycles, then IDLE.
REQ-021 gmii_tx_en, gmii_tx_er and gmii_txd are registered and appear one cycle after the state or byte that produces them; on-wire order: 7x 0x55, 0xD5, payload, pad 0x00, FCS.
REQ-022 The 11-bit byte counter counts payload+pad bytes; it clears in SFD and saturates at 2047.
REQ-023 On s_last accept: go to PAD if count after the byte < MIN_FRAME, else FCS.
REQ-024 A payload of exactly MIN_FRAME bytes produces no pad.
REQ-025 FCS: CRC-32 IEEE 802.3, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over payload+pad, transmitted as ~crc, byte [7:0] first.
REQ-026 Underrun: s_valid=0 during DATA drives one output cycle with gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00, pulses underrun and frame_done, and goes to IFG; the remainder of the frame is not consumed.
REQ-027 gmii_tx_er is 0 in every case except REQ-026.
REQ-028 IFG is counted from the first cycle gmii_tx_en is low; with s_valid held high, the next preamble starts exactly IFG_BYTES idle cycles after the previous en-low.
REQ-029 Maximum frame length is not enforced; the counter saturates and the FCS remains correct.

Reset
REQ-030 While gmii_tx_rst=1: state=IDLE, counters=0, CRC=0xFFFFFFFF, and gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00, s_ready=0, busy=0, frame_done=0, underrun=0 on the next edge.
REQ-031 Reset mid-frame truncates the frame with no tx_er and no frame_done; the upstream buffer flushes itself.

Structure
REQ-032 Shared package enet_pkg holds: FSM state enum, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC32_POLY=0xEDB88320, CRC32_INIT=0xFFFFFFFF, counter width 11.
REQ-033 Sub-module enet_crc32_d8: combinational next-CRC for one byte, inputs crc_in[31:0] and d[7:0], output crc_out[31:0]; the CRC register lives in enet_gmii_tx_ctrl.

Verification
REQ-034 Frame of 64 payload bytes 0x00..0x3F, no gaps -> en high for exactly 76 cycles (8+64+4), no pad, FCS equal to the bench reference CRC model, frame_done on the last FCS cycle.
REQ-035 Frame of 14 payload bytes -> exactly 46 bytes of 0x00 pad, en high for 72 cycles, FCS computed over all 60 bytes.
REQ-036 Two frames back-to-back with s_valid held high -> en low for exactly 12 cycles between them; second preamble byte is 0x55.
REQ-037 s_valid dropped after 20 accepted bytes -> one cycle with en=1, er=1, txd=0x00, underrun=1 and frame_done=1, then en low for 12 cycles, then IDLE.
REQ-038 gmii_tx_rst asserted during FCS byte 2 -> next cycle en=0, er=0, busy=0; a subsequent frame starts cleanly with CRC reinitialised.
REQ-039 MIN_FRAME=1 and IFG_BYTES=1 with a 1-byte payload -> en high for 13 cycles; next frame starts after 1 idle cycle.

Source files
------------

// File: rtl/enet_pkg.sv
// Shared definitions for the GMII transmit path: FSM states, framing bytes,
// CRC-32 constants and byte-counter width.
package enet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam int          CNT_W         = 11;
  localparam int          PRE_LEN       = 7;

endpackage

// File: rtl/enet_crc32_d8.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one byte, LSB first.
module enet_crc32_d8
  import enet_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    // NOTE: blocking assignments let the eight bit-steps chain within one evaluation;
    // clocked state elsewhere uses non-blocking so every register sees pre-edge values.
    c = crc_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/enet_gmii_tx_ctrl.sv
// GMII transmit framer: preamble/SFD, payload, zero pad to MIN_FRAME, CRC-32 FCS,
// inter-frame gap, with underrun abort signalled via gmii_tx_er.
module enet_gmii_tx_ctrl
  import enet_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       gmii_tx_rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
  localparam logic [7:0]       IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [2:0]       PRE_LAST = 3'(PRE_LEN - 1);

  tx_state_e        state, state_d;
  logic [2:0]       pre_cnt, pre_cnt_d;
  logic [1:0]       fcs_cnt, fcs_cnt_d;
  logic [7:0]       ifg_cnt, ifg_cnt_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d, cnt_inc;
  logic [31:0]      crc, crc_d, crc_next, crc_fcs;
  logic [7:0]       crc_byte;
  logic             en_d, er_d, done_d, underrun_d;
  logic [7:0]       txd_d;

  enet_crc32_d8 u_crc (
    .crc_in  (crc),
    .d       (crc_byte),
    .crc_out (crc_next)
  );

  assign crc_byte = (state == ST_PAD) ? 8'h00 : s_data;
  assign crc_fcs  = ~crc;
  // Saturate rather than wrap so oversize frames never look short enough to pad.
  assign cnt_inc  = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
  assign busy     = (state != ST_IDLE);
  assign s_ready  = (state == ST_DATA);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state;
    pre_cnt_d  = '0;
    fcs_cnt_d  = '0;
    ifg_cnt_d  = '0;
    byte_cnt_d = byte_cnt;
    crc_d      = crc;
    en_d       = 1'b0;
    er_d       = 1'b0;
    txd_d      = 8'h00;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    unique case (state)
      ST_IDLE: if (s_valid) state_d = ST_PRE;
      ST_PRE: begin
        en_d      = 1'b1;
        txd_d     = PREAMBLE_BYTE;
        pre_cnt_d = pre_cnt + 3'd1;
        if (pre_cnt == PRE_LAST) state_d = ST_SFD;
      end
      ST_SFD: begin
        en_d       = 1'b1;
        txd_d      = SFD_BYTE;
        byte_cnt_d = '0;
        crc_d      = CRC32_INIT;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        en_d = 1'b1;
        if (s_valid) begin
          txd_d      = s_data;
          byte_cnt_d = cnt_inc;
          crc_d      = crc_next;
          if (s_last) state_d = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
        end else begin
          er_d       = 1'b1;
          done_d     = 1'b1;
          underrun_d = 1'b1;
          state_d    = ST_IFG;
        end
      end
      ST_PAD: begin
        en_d       = 1'b1;
        byte_cnt_d = cnt_inc;
        crc_d      = crc_next;
        if (cnt_inc >= MIN_CNT) state_d = ST_FCS;
      end
      ST_FCS: begin
        en_d      = 1'b1;
        txd_d     = crc_fcs[{fcs_cnt, 3'b000} +: 8];
        fcs_cnt_d = fcs_cnt + 2'd1;
        if (fcs_cnt == 2'd3) begin
          done_d  = 1'b1;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        ifg_cnt_d = ifg_cnt + 8'd1;
        // The output register adds one idle wire cycle, so a waiting frame skips
        // IDLE and the gap on the wire is exactly IFG_BYTES.
        if (ifg_cnt == IFG_LAST) state_d = s_valid ? ST_PRE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (gmii_tx_rst) begin
      state      <= ST_IDLE;
      pre_cnt    <= '0;
      fcs_cnt    <= '0;
      ifg_cnt    <= '0;
      byte_cnt   <= '0;
      crc        <= CRC32_INIT;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_txd   <= 8'h00;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_d;
      pre_cnt    <= pre_cnt_d;
      fcs_cnt    <= fcs_cnt_d;
      ifg_cnt    <= ifg_cnt_d;
      byte_cnt   <= byte_cnt_d;
      crc        <= crc_d;
      gmii_tx_en <= en_d;
      gmii_tx_er <= er_d;
      gmii_txd   <= txd_d;
      frame_done <= done_d;
      underrun   <= underrun_d;
    end
  end

endmodule
